// File: rtl/cache_if.sv
// cache_if: request/response bundle between a requester and the cache controller
interface cache_if;
  logic        opcode;
  logic [7:0]  data_in;
  logic [31:0] address;
  logic [7:0]  data_out;
  logic        hit;
  logic        ready;
  modport master (output opcode, data_in, address, input data_out, hit, ready);
  modport slave  (input opcode, data_in, address, output data_out, hit, ready);
endinterface

// File: rtl/cache_controller.sv
// cache_controller: 4-way set-associative write-back/write-allocate byte cache with built-in backing memory
module cache_controller #(
  parameter int WAYS        = 4,
  parameter int SETS        = 16,
  parameter int LINE_BYTES  = 16,
  parameter int MEM_BYTES   = 4096,
  parameter int MEM_LATENCY = 4
) (
  input logic   clk,
  input logic   rst_b,
  cache_if.slave bus
);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - OW - IW;
  localparam int MW = $clog2(MEM_BYTES) - OW;
  localparam int CW = $clog2(MEM_LATENCY);
  localparam int WW = $clog2(WAYS);
  localparam int LB = 8 * LINE_BYTES;
  localparam logic [2:0] IDLE = 3'd0, LOOKUP = 3'd1, WRITEBACK = 3'd2, REFILL = 3'd3, DONE = 3'd4;
  logic [2:0]    st_q, st_d;
  logic [CW-1:0] cnt_q;
  logic          op_q, lhit_q, hit_q, rdy_q;
  logic [7:0]    din_q, dout_q;
  logic [31:0]   addr_q;
  logic [WW-1:0] way_q;
  logic [TW-1:0] tag_q   [SETS][WAYS];
  logic          valid_q [SETS][WAYS];
  logic          dirty_q [SETS][WAYS];
  logic [WW-1:0] age_q   [SETS][WAYS];
  logic [LB-1:0] line_q  [SETS][WAYS];
  logic [LB-1:0] mem_q   [2**MW];
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [OW-1:0] off;
  logic          mem_done, hit_w, inv_w;
  logic [WW-1:0] hway, iway, lway, vway;
  assign idx = addr_q[OW +: IW];
  assign tag = addr_q[31 -: TW];
  assign off = addr_q[OW-1:0];
  assign mem_done = cnt_q == CW'(MEM_LATENCY - 1);
  assign bus.data_out = dout_q;
  assign bus.hit = hit_q;
  assign bus.ready = rdy_q;
  // Descending scan so the lowest-numbered invalid way wins the victim choice
  always_comb begin
    hit_w = 1'b0;
    inv_w = 1'b0;
    hway = '0;
    iway = '0;
    lway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_w = 1'b1;
        hway = WW'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_w = 1'b1;
        iway = WW'(w);
      end
      if (age_q[idx][w] == WW'(WAYS - 1)) lway = WW'(w);
    end
    vway = hit_w ? hway : inv_w ? iway : lway;
  end
  always_comb
    st_d = st_q == IDLE      ? LOOKUP :
           st_q == LOOKUP    ? (hit_w ? DONE : (valid_q[idx][vway] && dirty_q[idx][vway]) ? WRITEBACK : REFILL) :
           st_q == WRITEBACK ? (mem_done ? REFILL : WRITEBACK) :
           st_q == REFILL    ? (mem_done ? DONE : REFILL) : IDLE;
  always_ff @(posedge clk) begin
    if (rst_b) begin
      st_q <= IDLE;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      hit_q <= 1'b0;
      dout_q <= 8'h00;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w] <= WW'(w);
        end
    end else begin
      st_q <= st_d;
      cnt_q <= ((st_q == WRITEBACK || st_q == REFILL) && !mem_done) ? cnt_q + 1'b1 : '0;
      rdy_q <= st_q == DONE;
      if (st_q == IDLE) begin
        op_q <= bus.opcode;
        din_q <= bus.data_in;
        addr_q <= bus.address;
      end
      if (st_q == LOOKUP) begin
        way_q <= vway;
        lhit_q <= hit_w;
      end
      if (st_q == REFILL && mem_done) begin
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= 1'b0;
        tag_q[idx][way_q] <= tag;
      end
      if (st_q == DONE) begin
        dout_q <= op_q ? din_q : line_q[idx][way_q][{off, 3'b000} +: 8];
        hit_q <= lhit_q;
        if (op_q) dirty_q[idx][way_q] <= 1'b1;
        for (int w = 0; w < WAYS; w++)
          age_q[idx][w] <= WW'(w) == way_q ? '0 :
                           age_q[idx][w] < age_q[idx][way_q] ? age_q[idx][w] + 1'b1 : age_q[idx][w];
      end
    end
  end
  // Line storage and backing memory; a reset in flight suppresses every write
  always_ff @(posedge clk) begin
    if (!rst_b && st_q == WRITEBACK && mem_done)
      mem_q[{tag_q[idx][way_q][MW-IW-1:0], idx}] <= line_q[idx][way_q];
    if (!rst_b && st_q == REFILL && mem_done)
      line_q[idx][way_q] <= mem_q[addr_q[OW +: MW]];
    if (!rst_b && st_q == DONE && op_q)
      line_q[idx][way_q][{off, 3'b000} +: 8] <= din_q;
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed plus randomized ops checked against a recency-list cache model
module tb_cache_controller;
  logic clk = 1'b0;
  logic rst_b = 1'b1;
  cache_if bus();
  cache_controller dut (.clk(clk), .rst_b(rst_b), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0;
  int errs = 0;
  bit [7:0]    m_mem [4096];
  int          m_n   [16];
  logic [23:0] m_tag [16][4];
  bit [7:0]    m_dat [16][4][16];
  bit          m_dirty [16][4];
  logic [23:0] pool [6] = '{24'h0, 24'h1, 24'h10, 24'h11, 24'h2F, 24'h1000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each set is a list of lines ordered most- to least-recently used
  task automatic model(input bit op, input logic [31:0] a, input bit [7:0] d,
                       output bit h, output bit [7:0] q, output int lat);
    int s = int'(a[7:4]);
    int o = int'(a[3:0]);
    logic [23:0] t = a[31:8];
    int i = -1;
    logic [23:0] tt;
    bit [7:0] td [16];
    bit tdy;
    for (int k = 0; k < m_n[s]; k++) if (m_tag[s][k] == t) i = k;
    h = i >= 0;
    lat = 2;
    if (i < 0) begin
      lat = 6;
      if (m_n[s] == 4) begin
        if (m_dirty[s][3]) begin
          lat = 10;
          for (int b = 0; b < 16; b++) m_mem[{m_tag[s][3][3:0], 4'(s), 4'(b)}] = m_dat[s][3][b];
        end
        m_n[s] = 3;
      end
      i = m_n[s];
      m_n[s]++;
      m_tag[s][i] = t;
      m_dirty[s][i] = 1'b0;
      for (int b = 0; b < 16; b++) m_dat[s][i][b] = m_mem[{t[3:0], 4'(s), 4'(b)}];
    end
    tt = m_tag[s][i];
    tdy = m_dirty[s][i];
    for (int b = 0; b < 16; b++) td[b] = m_dat[s][i][b];
    for (int k = i; k > 0; k--) begin
      m_tag[s][k] = m_tag[s][k-1];
      m_dirty[s][k] = m_dirty[s][k-1];
      for (int b = 0; b < 16; b++) m_dat[s][k][b] = m_dat[s][k-1][b];
    end
    m_tag[s][0] = tt;
    m_dirty[s][0] = tdy;
    for (int b = 0; b < 16; b++) m_dat[s][0][b] = td[b];
    if (op) begin
      m_dat[s][0][o] = d;
      m_dirty[s][0] = 1'b1;
    end
    q = m_dat[s][0][o];
  endtask

  task automatic do_op(input bit op, input logic [31:0] a, input bit [7:0] d, input bit scramble);
    bit eh;
    bit [7:0] eq;
    int el;
    int n = 0;
    model(op, a, d, eh, eq, el);
    bus.opcode = op;
    bus.data_in = d;
    bus.address = a;
    rst_b = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (scramble && n == 1) begin
        bus.opcode = 1'($urandom);
        bus.data_in = 8'($urandom);
        bus.address = $urandom;
      end
    end while (!bus.ready && n < 40);
    check($sformatf("ready %h", a), 32'(bus.ready), 32'd1);
    check($sformatf("latency %h", a), n - 1, el);
    check($sformatf("hit %h", a), 32'(bus.hit), 32'(eh));
    check($sformatf("data %h", a), 32'(bus.data_out), 32'(eq));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ready"}, 32'(bus.ready), 32'd0);
    check({tag, " hit"}, 32'(bus.hit), 32'd0);
    check({tag, " data"}, 32'(bus.data_out), 32'd0);
  endtask

  initial begin
    bus.opcode = 1'b0;
    bus.data_in = 8'h00;
    bus.address = 32'h10;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    do_op(0, 32'h10, 8'h00, 0);
    do_op(0, 32'h10, 8'h00, 0);
    do_op(1, 32'h80, 8'hA5, 0);
    do_op(0, 32'h80, 8'h00, 0);
    do_op(1, 32'h100, 8'hB6, 0);
    do_op(1, 32'h200, 8'hC7, 0);
    do_op(1, 32'h400, 8'hD8, 0);
    do_op(0, 32'h100, 8'h00, 0);
    do_op(0, 32'h200, 8'h00, 0);
    do_op(0, 32'h400, 8'h00, 0);
    do_op(1, 32'h800, 8'hE9, 0);
    do_op(0, 32'hC00, 8'h00, 0);
    do_op(0, 32'h100, 8'h00, 0);
    do_op(0, 32'h80, 8'h00, 0);
    // Abort a refill of an untouched set with a reset, then confirm the cache is cold
    bus.opcode = 1'b0;
    bus.address = 32'hF0;
    repeat (3) begin
      @(negedge clk);
      check("busy ready", 32'(bus.ready), 32'd0);
    end
    rst_b = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(negedge clk);
    check("midreset hold ready", 32'(bus.ready), 32'd0);
    for (int s = 0; s < 16; s++) m_n[s] = 0;
    do_op(0, 32'hF0, 8'h00, 0);
    do_op(0, 32'h80, 8'h00, 0);
    do_op(1, 32'h300, 8'h5A, 1);
    do_op(0, 32'h300, 8'h00, 1);
    for (int k = 0; k < 250; k++)
      do_op(1'($urandom), {pool[$urandom_range(0, 5)], 4'($urandom_range(0, 3)), 4'($urandom)},
            8'($urandom), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Byte-wide, 4-way set-associative, write-back / write-allocate cache controller with an integrated backing-memory model. It executes read/write requests presented on a 32-bit address bus and reports data, hit/miss and a completion strobe. It serves as the self-contained cache block of the memory subsystem; there is no external memory port.

Parameters:
WAYS, 4, associativity (fixed at 4; LRU logic sized for 4)
SETS, 16, number of sets; index = address[7:4]
LINE_BYTES, 16, bytes per line; offset = address[3:0]; tag = address[31:8] (24 bits)
MEM_BYTES, 4096, backing memory size, addressed by address[11:0] (higher bits alias)
MEM_LATENCY, 4, cycles per line refill or line writeback

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_b  in  1  synchronous reset, active-high (1 = reset) despite the name
opcode  in  1  0 = read, 1 = write
data_in  in  8  write data
address  in  32  byte address
data_out  out  8  byte at address after completed op (read data, or written byte)
hit  out  1  1 = completed op hit, 0 = miss; valid while ready=1, held afterwards
ready  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_b=1 at a rising edge): all valid/dirty bits cleared, LRU ages set to way number (way0=0 ... way3=3), FSM to IDLE, ready=0, hit=0, data_out=0x00. Backing memory is not reset; its contents are 0x00 at time zero. Reset mid-operation aborts the op with no memory update; dirty data in the cache is lost.
- No request-valid input: whenever the FSM is in IDLE it captures opcode, data_in and address and launches a transaction. A static input is therefore re-executed back-to-back; writes are idempotent.
- States: IDLE -> LOOKUP -> DONE -> IDLE on a hit. On a miss: LOOKUP -> (WRITEBACK if victim valid and dirty) -> REFILL -> DONE.
- LOOKUP: compare the captured tag against all valid ways of the set.
- WRITEBACK: hold MEM_LATENCY cycles, then write the 16-byte victim line to memory at {victim tag[3:0], index, 4'b0}.
- REFILL: hold MEM_LATENCY cycles, then load the 16-byte line, set valid, clear dirty.
- DONE: perform the access. A read returns the byte. A write stores data_in, sets dirty and returns data_in. Register data_out, register hit (1 if the LOOKUP hit), drive ready=1 for exactly this cycle.
- Latency from capture edge to ready high: hit 2 cycles; clean miss 2+MEM_LATENCY; dirty miss 2+2*MEM_LATENCY.
- Victim selection: lowest-numbered invalid way; otherwise the way with LRU age 3.
- LRU update in DONE: the accessed way's age becomes 0; ways younger than its old age increment by 1.
- Inputs may change while busy; only captured values are used.
- data_out and hit hold their last values between ready pulses.

Test Plan:
- Reset, then read 0x00000010 -> first ready: hit=0, data_out=0x00 after 2+MEM_LATENCY cycles; next ready for the same read: hit=1, data_out=0x00, 2 cycles later.
- Write 0xA5 to 0x00000080 -> first ready hit=0, data_out=0xA5; then read 0x00000080 -> hit=1, data_out=0xA5.
- Write 0xB6 to 0x100, 0xC7 to 0x200, 0xD8 to 0x400, all set 0 -> each first completion is a miss; readback of each hits and returns the written byte.
- Fill set 0 with 4 dirty lines, then access a fifth tag -> the LRU way is written back; latency is 2+2*MEM_LATENCY. Re-read the evicted address -> miss, returns its previously written byte from memory.
- Assert rst_b during REFILL -> ready stays 0, outputs go to 0; re-read of the same address -> miss.
- Change address while busy -> result reflects the originally captured address.
